// File: rtl/image_unblender_if.sv
// ---------------------------------------------------------------------------
// image_unblender_if
//   Valid/ready bundle for the image unblender.
//   Input side : in_valid / in_ready carry {blended_pixel, image_a,
//                blend_factor}, one pixel triple per transaction.
//   Output side: out_valid / out_ready carry {recovered_b, div_err}.
//   master = producer of pixels / consumer of results (upstream + downstream)
//   slave  = the unblender itself
// ---------------------------------------------------------------------------
interface image_unblender_if;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] blended_pixel;
  logic [15:0] image_a;
  logic [7:0]  blend_factor;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] recovered_b;
  logic        div_err;

  modport master (
    output in_valid, blended_pixel, image_a, blend_factor, out_ready,
    input  in_ready, out_valid, recovered_b, div_err
  );

  modport slave (
    input  in_valid, blended_pixel, image_a, blend_factor, out_ready,
    output in_ready, out_valid, recovered_b, div_err
  );
endinterface

// File: rtl/image_unblender.sv
// ---------------------------------------------------------------------------
// image_unblender
//   Recovers the second-image pixel B from a blended RGB565 pixel C, the
//   known first-image pixel A and the blend factor f:
//     B = (255*C - (255-f)*A) / f      per channel, floored and clamped
//   Three radix-2 restoring dividers (R, G, B) run in parallel for 14 cycles.
//   f == 0 short-circuits to recovered_b = 0 with div_err = 1.
//
//   Ports
//     clk    : rising-edge clock
//     reset  : synchronous, active-high
//     bus    : image_unblender_if.slave (in_valid/in_ready pixel input,
//              out_valid/out_ready result output)
// ---------------------------------------------------------------------------
module image_unblender (
  input  logic              clk,
  input  logic              reset,
  image_unblender_if.slave  bus
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_DIV  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam logic [3:0] LAST_STEP = 4'd13;

  // One restoring divider: dvd starts as the dividend and, one bit per step,
  // shifts out dividend bits on the left while quotient bits enter on the
  // right, so after 14 steps it holds the quotient.
  typedef struct packed {
    logic [13:0] dvd;
    logic [7:0]  rem;
  } div_t;

  logic [1:0]  state_q, state_d;
  logic [15:0] c_q, c_d;
  logic [15:0] a_q, a_d;
  logic [7:0]  f_q, f_d;
  logic [3:0]  cnt_q, cnt_d;
  div_t        ch_q [3];
  div_t        ch_d [3];
  logic [15:0] rec_q, rec_d;
  logic        err_q, err_d;

  logic [5:0]  q_r, q_g, q_b;

  // Channel i of an RGB565 pixel, zero-extended to 6 bits (0=R, 1=G, 2=B).
  function automatic logic [5:0] chan(input logic [15:0] p, input int i);
    case (i)
      0:       return {1'b0, p[15:11]};
      1:       return p[10:5];
      default: return {1'b0, p[4:0]};
    endcase
  endfunction

  // Positive part of 255*C - (255-f)*A. Worst case 255*63 = 16065 fits in
  // 14 bits unsigned, and comparing the two products avoids signed math.
  function automatic logic [13:0] dividend(input logic [5:0] c,
                                           input logic [5:0] a,
                                           input logic [7:0] f);
    logic [15:0] pos;
    logic [15:0] neg;
    pos = 16'(c) * 16'd255;
    neg = 16'(a) * (16'd255 - 16'(f));
    return (pos > neg) ? 14'(pos - neg) : 14'd0;
  endfunction

  // One restoring step. The partial remainder is always < f, so 8 bits hold
  // it and the shifted trial value needs 9.
  function automatic div_t div_step(input div_t s, input logic [7:0] f);
    div_t       n;
    logic [8:0] trial;
    logic       qbit;
    trial = {s.rem, s.dvd[13]};
    qbit  = (trial >= {1'b0, f});
    n.rem = qbit ? 8'(trial - {1'b0, f}) : trial[7:0];
    n.dvd = {s.dvd[12:0], qbit};
    return n;
  endfunction

  function automatic logic [5:0] clamp(input logic [13:0] q, input logic [5:0] max);
    return (q > 14'(max)) ? max : q[5:0];
  endfunction

  // NOTE: every signal assigned here gets a default first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    c_d     = c_q;
    a_d     = a_q;
    f_d     = f_q;
    cnt_d   = cnt_q;
    ch_d    = ch_q;
    rec_d   = rec_q;
    err_d   = err_q;
    q_r     = '0;
    q_g     = '0;
    q_b     = '0;

    case (state_q)
      S_IDLE: begin
        if (bus.in_valid) begin
          c_d     = bus.blended_pixel;
          a_d     = bus.image_a;
          f_d     = bus.blend_factor;
          state_d = S_CALC;
        end
      end

      S_CALC: begin
        if (f_q == 8'd0) begin
          rec_d   = 16'h0000;
          err_d   = 1'b1;
          state_d = S_DONE;
        end else begin
          err_d = 1'b0;
          for (int i = 0; i < 3; i++) begin
            ch_d[i].dvd = dividend(chan(c_q, i), chan(a_q, i), f_q);
            ch_d[i].rem = '0;
          end
          cnt_d   = '0;
          state_d = S_DIV;
        end
      end

      S_DIV: begin
        for (int i = 0; i < 3; i++) begin
          ch_d[i] = div_step(ch_q[i], f_q);
        end
        if (cnt_q == LAST_STEP) begin
          // The step computed this cycle completes the quotient, so pack
          // from the next-state values rather than waiting another cycle.
          q_r     = clamp(ch_d[0].dvd, 6'd31);
          q_g     = clamp(ch_d[1].dvd, 6'd63);
          q_b     = clamp(ch_d[2].dvd, 6'd31);
          rec_d   = {q_r[4:0], q_g, q_b[4:0]};
          cnt_d   = '0;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end

      S_DONE: begin
        if (bus.out_ready) begin
          state_d = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples its _d value from before the edge regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      c_q     <= '0;
      a_q     <= '0;
      f_q     <= '0;
      cnt_q   <= '0;
      rec_q   <= '0;
      err_q   <= 1'b0;
      // NOTE: the divider registers are small and are cleared on reset so a
      // discarded pixel leaves no stale partial quotient behind.
      for (int i = 0; i < 3; i++) begin
        ch_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      c_q     <= c_d;
      a_q     <= a_d;
      f_q     <= f_d;
      cnt_q   <= cnt_d;
      rec_q   <= rec_d;
      err_q   <= err_d;
      ch_q    <= ch_d;
    end
  end

  // in_ready is masked by reset so upstream never sees a ready that the
  // synchronous reset is about to override.
  assign bus.in_ready    = (state_q == S_IDLE) & ~reset;
  assign bus.out_valid   = (state_q == S_DONE);
  assign bus.recovered_b = rec_q;
  assign bus.div_err     = err_q;

endmodule

// File: doc/image_unblender.md
# image_unblender

Inverse of the pixel blender. Given a blended RGB565 pixel, the known first-image pixel `image_a`, and the blend factor used, it recovers an estimate of the second-image pixel. Per channel it computes B = (255·C − (255−f)·A) / f with three parallel iterative restoring dividers. It sits downstream of blended frame storage in the compositing path, behind valid/ready handshakes on both sides, and accepts one pixel per transaction.

## Interface
- No parameters. The format is fixed to RGB565, with R = [15:11], G = [10:5], B = [4:0].
- `clk`  in  1  system clock; all logic is on the rising edge
- `reset`  in  1  reset, synchronous, active-high
- `in_valid`  in  1  input pixel triple is valid
- `in_ready`  out  1  block can accept an input; equals (state == IDLE)
- `blended_pixel`  in  16  blended pixel C, RGB565
- `image_a`  in  16  known first-image pixel A, RGB565
- `blend_factor`  in  8  blend factor f; 0 = all A, 255 = all B
- `out_valid`  out  1  result is valid
- `out_ready`  in  1  downstream accepts the result
- `recovered_b`  out  16  recovered pixel B, RGB565
- `div_err`  out  1  f was 0, so B is unrecoverable; qualified by `out_valid`

## Operation
- FSM states: IDLE, CALC, DIV, DONE.
- **IDLE**
  - `in_ready` = 1.
  - On `in_valid & in_ready`: register C, A and f, then go to CALC.
- **CALC** (1 cycle). Per channel, form the signed numerator N = 255·C − (255−f)·A.
  - R/B (5-bit): N range ±7905, 14-bit signed.
  - G (6-bit): N range ±16065, 15-bit signed.
  - If N ≤ 0, the dividend is 0; otherwise the dividend is N as 14-bit unsigned.
  - If f == 0: `recovered_b` = 0x0000, `div_err` = 1, go to DONE.
  - Otherwise: `div_err` = 0, load the dividers, clear the bit counter, go to DIV.
- **DIV** (exactly 14 cycles).
  - Radix-2 restoring division, one quotient bit per cycle for all three channels in parallel, divisor = f (8-bit).
  - The counter runs 0..13; on count 13, go to DONE.
- Result of the division:
  - Quotient is the floor; the remainder is discarded.
  - Clamp the quotient to the channel maximum: R/B to 31, G to 63.
  - Pack as {R, G, B} into `recovered_b` on entry to DONE.
- **DONE**
  - `out_valid` = 1.
  - `recovered_b` and `div_err` are held stable while `out_valid & !out_ready`.
  - On `out_valid & out_ready`: go to IDLE.
- The inverse is lossy because the forward blend floors its result. No attempt is made to reconstruct bits lost in the forward blend.
- Simultaneous events:
  - The output handshake and a new `in_valid` in the same cycle: the input is NOT accepted, because `in_ready` = 0 in DONE.
  - It is accepted no earlier than the next cycle, in IDLE.
- Input changes while not in IDLE are ignored, since all inputs are registered at acceptance.

## Timing
- Reset values: `in_ready` = 0 during reset and 1 in the first cycle after reset deasserts. `out_valid` = 0, `recovered_b` = 0x0000, `div_err` = 0. FSM = IDLE, counter = 0, dividers = 0.
- Reset mid-operation (CALC, DIV or DONE): the in-flight pixel is discarded, all outputs return to reset values on the next edge, and no `out_valid` is produced for it.
- Latency with the acceptance edge at T:
  - CALC occupies the cycle after T.
  - DIV occupies the next 14 cycles.
  - `out_valid` rises 16 cycles after T.
- Latency for f == 0: `out_valid` rises 2 cycles after T.
- Throughput: with `out_ready` tied high, one pixel per 17 cycles (1 IDLE + 1 CALC + 14 DIV + 1 DONE). With f == 0, one pixel per 3 cycles.
- `out_valid` never drops without a completed output handshake, except on reset.

## Test plan
- Identity round-trip: C = 0xFFFF, A = 0xFFFF, f = 128 → `recovered_b` = 0xFFFF, `div_err` = 0, `out_valid` 16 cycles after acceptance.
- Pure B: C = 0xF800, A = 0x0000, f = 255 → 0xF800. Lossy case: C = 0x0300, A = 0x0000, f = 100 → G = floor(6120/100) = 61, giving 0x07A0.
- Negative and clamp: C = 0x0000, A = 0xFFFF, f = 128 → 0x0000 with `div_err` = 0. C = 0xFFFF, A = 0x0000, f = 1 → clamped to 0xFFFF.
- f = 0: any C/A → `recovered_b` = 0x0000, `div_err` = 1, `out_valid` 2 cycles after acceptance.
- Backpressure: hold `out_ready` = 0 for 5 cycles in DONE → outputs stable and `in_ready` = 0 throughout. Drive `in_valid` high during the handshake cycle → not accepted until the following IDLE cycle.
- Reset mid-DIV: assert `reset` at DIV cycle 7 → `out_valid` never asserts for that pixel. The next pixel after reset completes with correct latency and value.
